icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache between the datapath fetch stage and `memory_control`. It serves instruction reads from a 16-frame, one-word-per-frame array. On a miss it issues a single-word read on the `memory_control` instruction port, fills the frame, and then replays the access as a hit. The block also provides a whole-cache invalidate for halt and reload.

## Interface
- `SETS`, 16: number of frames, a power of two; index width is log2(SETS).
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `imemREN` in 1: datapath fetch request.
- `imemaddr` in 32: byte address of the fetch; bits [1:0] are ignored.
- `ihit` out 1: `imemload` is valid this cycle.
- `imemload` out 32: fetched instruction.
- `flush` in 1: invalidate all frames.
- `iREN` out 1: read request to `memory_control`.
- `iaddr` out 32: word-aligned read address to `memory_control`.
- `iwait` in 1: `memory_control` is busy; low means `iload` is valid.
- `iload` in 32: read data from `memory_control`.

## Operation
- Address split, via the package `icachef_t`:
  - tag = [31:2+log2(SETS)]
  - idx = [1+log2(SETS):2]
  - bytoff = [1:0]
  - For SETS=16: tag[31:6], idx[5:2].
- Frame contents: valid bit, tag, data word.
- Hit condition: `imemREN & valid[idx] & tag[idx]==addr.tag & state==IDLE`.
- On a hit:
  - `ihit`=1 combinationally.
  - `imemload`=data[idx].
- States:
  - **IDLE**
    - Hit: stay in IDLE.
    - `imemREN` && !hit && !`flush`: go to FETCH.
  - **FETCH**
    - `iREN`=1.
    - `iaddr`={`imemaddr`[31:2],2'b00}.
    - `iwait`=1: stay in FETCH.
    - `iwait`=0: write {1, tag, `iload`} into frame idx and go to IDLE. `ihit` stays 0 in this cycle.
- The address must be held stable by the datapath while `ihit`=0. If `imemaddr` changes during FETCH, the fill uses the address present in the `iwait`=0 cycle.
- `imemREN` dropping during FETCH:
  - Go to IDLE on the next edge without filling.
  - Drop `iREN` combinationally in that same cycle.
- `flush`:
  - Clears every valid bit on the next edge.
  - Forces the state to IDLE, abandoning any fill.
  - Suppresses `ihit` and `iREN` in the same cycle.
- Outputs when not hitting:
  - `imemload`=0 when `ihit`=0.
  - `iREN`=0 and `iaddr`=0 outside FETCH.
- `RST`:
  - Valid bits cleared, state IDLE. Tags and data are don't-care.
  - Reset applied mid-FETCH abandons the read; `iREN` is 0 from the cycle after the reset edge.
  - Until the first fetch, outputs are `ihit`=0, `imemload`=0, `iREN`=0, `iaddr`=0.

## Timing
- Hit latency: 0 cycles (combinational from address to `ihit`/`imemload`).
- Miss timeline:
  - Cycle 0: lookup misses.
  - Cycle 1: FETCH, `iREN` asserted.
  - Final FETCH cycle: `iwait`=0, fill on that edge.
  - Next cycle: IDLE hit.
- Total miss latency is 2 + N cycles, where N is the number of FETCH cycles with `iwait`=1.
- `iREN` is never asserted in IDLE; no speculative prefetch.
- Simultaneous `flush` and a fill edge: flush wins, and the frame is left invalid.

## Structure
- Shared in `cpu_types_pkg`:
  - `word_t`
  - `icachef_t` (packed tag/idx/bytoff struct)
  - `ITAG_W` and `IIDX_W` constants
  - state enum `icache_state_t` {IDLE, FETCH}
- Frame array is a local `icache_frame_t` struct array in the package.
- No sub-module: a single always_ff for the array and state, plus always_comb for the hit, next-state and output logic.

## Test plan
- **Cold miss:** after RST, `imemREN`=1, `imemaddr`=0x40, RAM returns 0x8C010004 after 3 wait cycles.
  - `iREN`=1 with `iaddr`=0x40 during FETCH.
  - `ihit`=1 with `imemload`=0x8C010004 exactly one cycle after `iwait` falls.
- **Re-read:** 0x40 again.
  - `ihit`=1 in the same cycle.
  - `iREN` stays 0.
- **Conflict:** 0x80, same idx 0 with a different tag.
  - Miss and refill to the 0x80 data.
  - A subsequent read of 0x40 misses again.
- **Byte offset:** `imemaddr`=0x43 after 0x40 is cached.
  - Hit returning the 0x40 word.
  - `iaddr` on any miss always has [1:0]=00.
- **Flush:** assert `flush` with 0x40 cached, then read 0x40.
  - Miss, and `iREN` asserted.
  - `flush` asserted mid-FETCH: no fill, state IDLE next cycle.
- **Reset mid-FETCH:** assert `RST` while `iwait`=1.
  - `iREN`=0 the cycle after the reset edge.
  - All prior contents miss afterward.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, instruction-cache address split, frame layout and FSM states.
package cpu_types_pkg;

    localparam int ICACHE_SETS = 16;
    localparam int IIDX_W      = $clog2(ICACHE_SETS);
    localparam int ITAG_W      = 32 - IIDX_W - 2;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only, one-word-per-frame instruction cache with single-word
// miss refill from memory_control and whole-cache flush.
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output logic  ihit,
    output word_t imemload,
    input  logic  flush,
    output logic  iREN,
    output word_t iaddr,
    input  logic  iwait,
    input  word_t iload
);

    icachef_t      addr_s;
    icache_frame_t frames_r [SETS];
    icache_state_t state_r;
    logic          hit_s;
    logic          unused_s;

    assign addr_s   = icachef_t'(imemaddr);
    assign unused_s = ^addr_s.bytoff;

    // Lookup, hit and memory-request outputs; flush masks both hit and request.
    always_comb begin
        hit_s    = 1'b0;
        ihit     = 1'b0;
        imemload = 32'h0;
        iREN     = 1'b0;
        iaddr    = 32'h0;
        hit_s = imemREN && frames_r[addr_s.idx].valid
                && (frames_r[addr_s.idx].tag == addr_s.tag)
                && (state_r == IDLE) && !flush;
        ihit = hit_s;
        if (hit_s) begin
            imemload = frames_r[addr_s.idx].data;
        end else begin
            imemload = 32'h0;
        end
        if (state_r == FETCH) begin
            iREN  = imemREN && !flush;
            iaddr = {imemaddr[31:2], 2'b00};
        end else begin
            iREN  = 1'b0;
            iaddr = 32'h0;
        end
    end

    // Frame array and miss FSM; the fill takes the address present in the iwait=0 cycle.
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            for (int i = 0; i < SETS; i++) begin
                frames_r[i].valid <= 1'b0;
            end
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (imemREN && !hit_s) begin
                        state_r <= FETCH;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FETCH: begin
                    if (!imemREN) begin
                        state_r <= IDLE;
                    end else if (!iwait) begin
                        frames_r[addr_s.idx] <= '{valid: 1'b1, tag: addr_s.tag, data: iload};
                        state_r              <= IDLE;
                    end else begin
                        state_r <= FETCH;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed test-plan cases plus random fetch traffic
// against a model that tracks which word address each frame holds.
module tb_icache;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  RST, imemREN, flush, iwait;
    word_t imemaddr, iload, imemload, iaddr;
    logic  ihit, iREN;

    int n_cmp = 0;
    int n_err = 0;
    int cached [16];   // word address held by each frame, -1 when invalid

    icache #(.SETS(16)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
        .iaddr(iaddr), .iwait(iwait), .iload(iload)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic word_t mem_of(input word_t a);
        word_t w;
        w = {a[31:2], 2'b00};
        if (w == 32'h40) return 32'h8C010004;
        return (w * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) cached[i] = -1;
    endtask

    // One complete fetch of addr with 'waits' busy cycles on a miss.
    task automatic do_fetch(input word_t addr, input int waits);
        int    idx;
        int    wa;
        word_t exp_addr;
        idx      = int'(addr[5:2]);
        wa       = int'(addr[31:2]);
        exp_addr = {addr[31:2], 2'b00};
        imemREN  = 1'b1;
        imemaddr = addr;
        iwait    = 1'b1;
        iload    = $urandom;
        #1;
        if (cached[idx] == wa) begin
            check("hit", {31'd0, ihit}, 32'd1);
            check("hit_data", imemload, mem_of(addr));
            check("hit_no_iren", {31'd0, iREN}, 32'd0);
            tick();
        end else begin
            check("miss", {31'd0, ihit}, 32'd0);
            check("miss_load0", imemload, 32'h0);
            check("idle_iren", {31'd0, iREN}, 32'd0);
            tick();
            for (int w = 0; w < waits; w++) begin
                check("fetch_iren", {31'd0, iREN}, 32'd1);
                check("fetch_iaddr", iaddr, exp_addr);
                check("fetch_nohit", {31'd0, ihit}, 32'd0);
                iload = $urandom;
                tick();
            end
            iwait = 1'b0;
            iload = mem_of(addr);
            #1;
            check("last_iren", {31'd0, iREN}, 32'd1);
            check("last_iaddr", iaddr, exp_addr);
            check("last_nohit", {31'd0, ihit}, 32'd0);
            tick();
            iwait = 1'b1;
            iload = $urandom;
            cached[idx] = wa;
            #1;
            check("replay_hit", {31'd0, ihit}, 32'd1);
            check("replay_data", imemload, mem_of(addr));
            check("replay_iren", {31'd0, iREN}, 32'd0);
            tick();
        end
        imemREN = 1'b0;
    endtask

    // Enter FETCH for a (known-miss) addr and spend one busy cycle there.
    task automatic enter_fetch(input word_t addr);
        imemREN  = 1'b1;
        imemaddr = addr;
        iwait    = 1'b1;
        tick();
        check("ef_iren", {31'd0, iREN}, 32'd1);
        tick();
    endtask

    initial begin
        RST = 1'b1; imemREN = 1'b0; flush = 1'b0; iwait = 1'b1;
        imemaddr = 32'h0; iload = 32'h0;
        model_clear();
        tick(); tick();
        RST = 1'b0;
        #1;
        check("rst_ihit", {31'd0, ihit}, 32'd0);
        check("rst_load", imemload, 32'h0);
        check("rst_iren", {31'd0, iREN}, 32'd0);
        check("rst_iaddr", iaddr, 32'h0);
        tick();

        // Cold miss with 3 wait cycles, then re-read and byte offset.
        do_fetch(32'h40, 3);
        do_fetch(32'h40, 0);
        do_fetch(32'h43, 0);
        // Conflict on idx 0 evicts 0x40.
        do_fetch(32'h80, 2);
        do_fetch(32'h40, 1);

        // Flush suppresses a same-cycle hit and invalidates.
        imemREN = 1'b1; imemaddr = 32'h40; flush = 1'b1;
        #1;
        check("flush_nohit", {31'd0, ihit}, 32'd0);
        check("flush_noiren", {31'd0, iREN}, 32'd0);
        tick();
        flush = 1'b0; imemREN = 1'b0;
        model_clear();
        do_fetch(32'h40, 1);

        // Flush coincident with the fill edge: no fill, IDLE next.
        enter_fetch(32'h104);
        iwait = 1'b0; iload = mem_of(32'h104); flush = 1'b1;
        #1;
        check("flushfill_iren", {31'd0, iREN}, 32'd0);
        tick();
        flush = 1'b0; imemREN = 1'b0; iwait = 1'b1;
        #1;
        check("flushfill_idle", iaddr, 32'h0);
        model_clear();
        do_fetch(32'h104, 0);

        // imemREN dropping mid-FETCH abandons without fill.
        enter_fetch(32'h208);
        imemREN = 1'b0;
        #1;
        check("drop_iren", {31'd0, iREN}, 32'd0);
        tick();
        check("drop_idle", iaddr, 32'h0);
        do_fetch(32'h208, 1);

        // Reset mid-FETCH.
        enter_fetch(32'h30C);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        check("rstf_iren", {31'd0, iREN}, 32'd0);
        check("rstf_nohit", {31'd0, ihit}, 32'd0);
        imemREN = 1'b0;
        tick();
        model_clear();
        do_fetch(32'h40, 0);
        do_fetch(32'h208, 0);

        // Random traffic over 4 tags x 16 frames with occasional flushes.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                flush = 1'b1; imemREN = 1'b0;
                tick();
                flush = 1'b0;
                model_clear();
            end else begin
                do_fetch({24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))},
                         $urandom_range(0, 3));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
